// File: rtl/prio_enc_pkg.sv
// Shared types for the priority-encoder link (encoder and decoder sides).
// Contents:
//   CODE_W, OUT_W   code width and one-hot vector width (OUT_W = 1 << CODE_W)
//   code_t, vec_t   encoded index and decoded vector types
//   occ_state_t     occupancy states of the decoder FIFO
//   decode()        code/hit pair -> one-hot vector, all-zero when hit=0
package prio_enc_pkg;

  localparam int CODE_W = 2;
  localparam int OUT_W  = 1 << CODE_W;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [OUT_W-1:0]  vec_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  // Compare-based decode rather than a shift: an unknown code can only
  // clear bits, and when hit=0 the code is never looked at.
  function automatic vec_t decode(input code_t code, input logic hit);
    vec_t v;
    v = '0;
    if (hit) begin
      for (int i = 0; i < OUT_W; i++) begin
        if (code == code_t'(i)) begin
          v[i] = 1'b1;
        end else begin
          v[i] = 1'b0;
        end
      end
    end else begin
      v = '0;
    end
    return v;
  endfunction

endpackage

// File: rtl/prio_dec_fifo.sv
// Small in-order FIFO holding decoded vectors between the link and the consumer.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   push, wdata   write strobe and data (ignored while full)
//   pop           read strobe (ignored while empty)
//   rdata         registered head entry, all-zero while empty
//   full          registered; also held high during reset so nothing is pushed
//   empty         registered from the occupancy FSM
module prio_dec_fifo
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  occ_state_t       r_state;
  logic [WIDTH-1:0] r_head;
  logic             r_full;

  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_nxt;
  logic [AW-1:0]    w_wptr_nxt;
  logic [AW-1:0]    w_rptr_nxt;
  occ_state_t       w_state_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_push = push & ~r_full;
  assign w_pop  = pop & (r_state != OCC_EMPTY);

  // Next occupancy, pointers and head entry.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1'b1);
      2'b01:   w_count_nxt = r_count - CW'(1'b1);
      default: w_count_nxt = r_count;
    endcase

    if (w_push) begin
      w_wptr_nxt = r_wptr + AW'(1'b1);
    end else begin
      w_wptr_nxt = r_wptr;
    end

    if (w_pop) begin
      w_rptr_nxt = r_rptr + AW'(1'b1);
    end else begin
      w_rptr_nxt = r_rptr;
    end

    if (w_count_nxt == CW'(1'b0)) begin
      w_state_nxt = OCC_EMPTY;
    end else if (w_count_nxt == CW'(DEPTH)) begin
      w_state_nxt = OCC_FULL;
    end else begin
      w_state_nxt = OCC_PARTIAL;
    end

    // The new head comes straight from wdata when the entry being written
    // is the one the read pointer lands on (push into empty, or push&pop at 1).
    if (w_count_nxt == CW'(1'b0)) begin
      w_head_nxt = '0;
    end else if (w_push && (w_rptr_nxt == r_wptr)) begin
      w_head_nxt = wdata;
    end else begin
      w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  // Storage array write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr] <= wdata;
    end else begin
      r_mem[r_wptr] <= r_mem[r_wptr];
    end
  end

  // Occupancy FSM with registered head, full and empty outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OCC_EMPTY;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_head  <= '0;
      r_full  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_head  <= w_head_nxt;
      r_full  <= (w_state_nxt == OCC_FULL);
    end
  end

  assign rdata = r_head;
  assign full  = r_full;
  assign empty = (r_state == OCC_EMPTY);

endmodule

// File: rtl/priority_dec_stream.sv
// Receive side of the priority-encoder link: (code, hit) frames are decoded to
// a one-hot vector (all-zero when hit=0) and queued for the consumer.
// CODE_W / OUT_W come from prio_enc_pkg.
// Parameters: DEPTH (FIFO entries, power of two >= 2), CNT_W (hit counter width).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_ready is registered
//   in_code, in_hit      encoded index and encoder-valid flag
//   out_valid/out_ready  downstream handshake
//   out_vec              decoded vector, zero while out_valid=0
//   hit_count            saturating count of accepted frames with in_hit=1
// Build option PRIO_DEC_CHECK_EN adds err_sticky: set on an accepted hit frame
// with unknown code bits, or on an accepted no-hit frame carrying a non-zero
// code once hits have been seen; cleared only by rst.
module priority_dec_stream
  import prio_enc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  code_t            in_code,
  input  logic             in_hit,
  output logic             out_valid,
  input  logic             out_ready,
  output vec_t             out_vec,
  output logic [CNT_W-1:0] hit_count
`ifdef PRIO_DEC_CHECK_EN
  ,output logic            err_sticky
`endif
);

  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_pop;
  vec_t             w_dec_vec;
  logic [CNT_W-1:0] r_hit_count;

  assign w_dec_vec = decode(in_code, in_hit);
  assign w_accept  = in_valid & ~w_full;
  assign w_pop     = ~w_empty & out_ready;

  prio_dec_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_accept),
    .wdata (w_dec_vec),
    .pop   (w_pop),
    .rdata (out_vec),
    .full  (w_full),
    .empty (w_empty)
  );

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;

  // Saturating count of accepted hit frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count <= '0;
    end else if (w_accept && in_hit && (r_hit_count != {CNT_W{1'b1}})) begin
      r_hit_count <= r_hit_count + CNT_W'(1'b1);
    end else begin
      r_hit_count <= r_hit_count;
    end
  end

  assign hit_count = r_hit_count;

`ifdef PRIO_DEC_CHECK_EN
  logic r_err_sticky;
  logic w_err_event;

  assign w_err_event = w_accept &
                       ((in_hit & $isunknown(in_code)) |
                        (~in_hit & (r_hit_count != '0) & (in_code != '0)));

  // Sticky link-integrity flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sticky <= 1'b0;
    end else if (w_err_event) begin
      r_err_sticky <= 1'b1;
    end else begin
      r_err_sticky <= r_err_sticky;
    end
  end

  assign err_sticky = r_err_sticky;
`endif

endmodule

// File: tb/tb_priority_dec_stream.sv
module tb_priority_dec_stream;
  import prio_enc_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int HMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  code_t            in_code;
  logic             in_hit;
  logic             out_valid;
  logic             out_ready;
  vec_t             out_vec;
  logic [CNT_W-1:0] hit_count;
`ifdef PRIO_DEC_CHECK_EN
  logic             err_sticky;
`endif

  int checks = 0;
  int errors = 0;

  vec_t exp_q[$];
  int   exp_hits = 0;
  bit   post_rst = 1'b0;

  priority_dec_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_hit    (in_hit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .hit_count (hit_count)
`ifdef PRIO_DEC_CHECK_EN
    ,.err_sticky (err_sticky)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t ref_vec(input int code, input bit hit);
    vec_t v;
    v = '0;
    if (hit) v[code] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: compares DUT state against the queue model, then
  // applies this cycle's handshakes to the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_vec", 32'(out_vec), 32'd0);
      chk("rst_hit_count", 32'(hit_count), 32'd0);
      exp_q.delete();
      exp_hits = 0;
      post_rst = 1'b1;
    end else begin
      chk("in_ready", 32'(in_ready), 32'((!post_rst) && (exp_q.size() < DEPTH)));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("hit_count", 32'(hit_count), 32'(exp_hits));
      if (exp_q.size() == 0) chk("out_vec_empty", 32'(out_vec), 32'd0);
      else                   chk("out_vec", 32'(out_vec), 32'(exp_q[0]));
      if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_vec(int'(in_code), in_hit));
        if (in_hit && exp_hits < HMAX) exp_hits++;
      end
      post_rst = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int code, input bit hit);
    bit acc;
    int budget;
    in_valid = 1'b1;
    in_code  = code_t'(code);
    in_hit   = hit;
    acc      = 1'b0;
    budget   = 0;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required acceptance within 50 cycles");
    end
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst = 1'b1; in_valid = 1'b0; in_code = '0; in_hit = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Codes 0..3 with hit, consumer always ready.
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) send(c, 1'b1);
    step(); step();
    chk("hits_after_4", 32'(hit_count), 32'd4);

    // No-hit frame with a non-zero code decodes to zero.
    send(3, 1'b0);
    step(); step();
    chk("hits_unchanged", 32'(hit_count), 32'd4);

    // Backpressure: two frames fill the FIFO, the third is held.
    out_ready = 1'b0;
    send(1, 1'b1);
    send(2, 1'b1);
    in_valid = 1'b1; in_code = code_t'(3); in_hit = 1'b1;
    repeat (3) step();
    chk("held_in_ready", 32'(in_ready), 32'd0);
    chk("held_out_vec", 32'(out_vec), 32'h2);
    out_ready = 1'b1;
    send(3, 1'b1);
    repeat (3) step();

    // Steady state at occupancy 1: one vector per cycle.
    out_ready = 1'b0;
    send(0, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(int'($urandom_range(3)), 1'($urandom_range(1)));
    repeat (3) step();

    // Reset mid-stream with two entries stored.
    out_ready = 1'b0;
    send(1, 1'b1);
    send(2, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_hit_count", 32'(hit_count), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Saturation of the hit counter.
    out_ready = 1'b1;
    for (int i = 0; i < HMAX + 5; i++) send(int'($urandom_range(3)), 1'b1);
    step(); step();
    chk("hit_saturated", 32'(hit_count), 32'(HMAX));

    // Randomised traffic; an unaccepted frame is held by the source.
    pulse_rst();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(3) != 0);
        in_code  = code_t'($urandom_range(3));
        in_hit   = ($urandom_range(3) != 0);
      end
      out_ready = ($urandom_range(2) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    chk("drained_out_valid", 32'(out_valid), 32'd0);

`ifdef PRIO_DEC_CHECK_EN
    pulse_rst();
    chk("err_reset", 32'(err_sticky), 32'd0);
    send(1, 1'b1);
    chk("err_clean", 32'(err_sticky), 32'd0);
    send(2, 1'b0);
    step();
    chk("err_set", 32'(err_sticky), 32'd1);
    repeat (3) step();
    chk("err_held", 32'(err_sticky), 32'd1);
    pulse_rst();
    chk("err_cleared", 32'(err_sticky), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
